// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the two-way traffic-light controller:
// phase enum, lamp bundle, phase sequencing and per-phase load value.
package semaforo_pkg;

    typedef enum logic [2:0] {
        A_VERDE,
        A_AMARILLO,
        ROJO1,
        B_VERDE,
        B_AMARILLO,
        ROJO2
    } estado_t;

    typedef struct packed {
        logic rojo_a;
        logic amarillo_a;
        logic verde_a;
        logic rojo_b;
        logic amarillo_b;
        logic verde_b;
    } luces_t;

    function automatic estado_t siguiente(estado_t e);
        estado_t s;
        unique case (e)
            A_VERDE:    s = A_AMARILLO;
            A_AMARILLO: s = ROJO1;
            ROJO1:      s = B_VERDE;
            B_VERDE:    s = B_AMARILLO;
            B_AMARILLO: s = ROJO2;
            default:    s = A_VERDE;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] duracion(
        estado_t    e,
        logic [3:0] tv,
        logic [3:0] ta,
        logic [3:0] tr
    );
        logic [3:0] d;
        unique case (e)
            A_VERDE, B_VERDE:       d = tv;
            A_AMARILLO, B_AMARILLO: d = ta;
            default:                d = tr;
        endcase
        return d;
    endfunction

    function automatic luces_t luces(estado_t e);
        luces_t l;
        l = '0;
        unique case (e)
            A_VERDE:    begin l.verde_a    = 1'b1; l.rojo_b = 1'b1; end
            A_AMARILLO: begin l.amarillo_a = 1'b1; l.rojo_b = 1'b1; end
            B_VERDE:    begin l.rojo_a = 1'b1; l.verde_b    = 1'b1; end
            B_AMARILLO: begin l.rojo_a = 1'b1; l.amarillo_b = 1'b1; end
            default:    begin l.rojo_a = 1'b1; l.rojo_b     = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_temporizador_divisor.sv
// divisor_segundo: one-second prescaler. Counts 0..CLK_HZ-1 and
// registers a one-cycle Tick pulse after the terminal count.
// Ports: Clk, Reset_n (async, active-low), Tick (out).
module divisor_segundo #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic Tick
);

    localparam int W = (CLK_HZ < 2) ? 1 : $clog2(CLK_HZ);
    localparam logic [W-1:0] ULTIMO = W'(CLK_HZ - 1);

    if (CLK_HZ < 2) begin : g_clk_check
        $error("divisor_segundo: CLK_HZ must be >= 2");
    end

    logic [W-1:0] cuenta;
    logic         fin;

    assign fin = (cuenta == ULTIMO);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cuenta <= '0;
            Tick   <= 1'b0;
        end else begin
            Tick   <= fin;
            cuenta <= fin ? '0 : cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/semaforo_temporizador.sv
// Two-way traffic-light FSM with a seconds countdown (Numero) and
// registered lamp outputs. Tick1s pulses once per second.
// Ports: Clk, Reset_n (async, active-low), [Peaton], Numero[3:0],
// RojoA/AmarilloA/VerdeA, RojoB/AmarilloB/VerdeB, Tick1s.
// Option SEMAFORO_PEATON_EN: pedestrian request shortens green to 3 s.
module semaforo_temporizador
    import semaforo_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int T_VERDE    = 9,
    parameter int T_AMARILLO = 3,
    parameter int T_TODOROJO = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
`ifdef SEMAFORO_PEATON_EN
    input  logic       Peaton,
`endif
    output logic [3:0] Numero,
    output logic       RojoA,
    output logic       AmarilloA,
    output logic       VerdeA,
    output logic       RojoB,
    output logic       AmarilloB,
    output logic       VerdeB,
    output logic       Tick1s
);

    if (T_VERDE < 1 || T_VERDE > 9 ||
        T_AMARILLO < 1 || T_AMARILLO > 9 ||
        T_TODOROJO < 1 || T_TODOROJO > 9 ||
        CLK_HZ < 2) begin : g_param_check
        $error("semaforo_temporizador: illegal parameter");
    end

    localparam logic [3:0] TV = 4'(T_VERDE);
    localparam logic [3:0] TA = 4'(T_AMARILLO);
    localparam logic [3:0] TR = 4'(T_TODOROJO);

    logic       tick;
    estado_t    estado;
    estado_t    estado_sig;
    logic [3:0] numero;
    logic [3:0] numero_sig;
    luces_t     lamparas;

    divisor_segundo #(
        .CLK_HZ (CLK_HZ)
    ) u_divisor (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Tick    (tick)
    );

`ifdef SEMAFORO_PEATON_EN
    logic peaton_s1;
    logic peaton_s2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            peaton_s1 <= 1'b0;
            peaton_s2 <= 1'b0;
        end else begin
            peaton_s1 <= Peaton;
            peaton_s2 <= peaton_s1;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            estado   <= A_VERDE;
            numero   <= TV;
            lamparas <= luces(A_VERDE);
        end else begin
            estado   <= estado_sig;
            numero   <= numero_sig;
            // decoded from the next state so lamps and Numero change together
            lamparas <= luces(estado_sig);
        end
    end

    always_comb begin
        estado_sig = estado;
        numero_sig = numero;
        if (tick) begin
            if (numero > 4'd1) begin
                numero_sig = numero - 4'd1;
            end else begin
                estado_sig = siguiente(estado);
                numero_sig = duracion(estado_sig, TV, TA, TR);
            end
        end
`ifdef SEMAFORO_PEATON_EN
        // numero > 3 excludes the advance branch, so state is unchanged
        if (peaton_s2 && numero > 4'd3 &&
            (estado == A_VERDE || estado == B_VERDE)) begin
            numero_sig = 4'd3;
        end
`endif
    end

    assign Numero    = numero;
    assign RojoA     = lamparas.rojo_a;
    assign AmarilloA = lamparas.amarillo_a;
    assign VerdeA    = lamparas.verde_a;
    assign RojoB     = lamparas.rojo_b;
    assign AmarilloB = lamparas.amarillo_b;
    assign VerdeB    = lamparas.verde_b;
    assign Tick1s    = tick;

endmodule

// File: tb/tb_semaforo_temporizador.sv
// Scoreboard bench for semaforo_temporizador with CLK_HZ=10.
// A second instance uses T_AMARILLO=1 for the short-yellow edge case.
module tb_semaforo_temporizador;

    logic       clk;
    logic       rst_n;
`ifdef SEMAFORO_PEATON_EN
    logic       peaton;
`endif

    logic [3:0] numero;
    logic       ra, aa, va, rb, ab, vb, tick;
    logic [3:0] numero1;
    logic       ra1, aa1, va1, rb1, ab1, vb1, tick1;

    semaforo_temporizador #(
        .CLK_HZ(10), .T_VERDE(9), .T_AMARILLO(3), .T_TODOROJO(1)
    ) u_dut (
        .Clk(clk), .Reset_n(rst_n),
`ifdef SEMAFORO_PEATON_EN
        .Peaton(peaton),
`endif
        .Numero(numero),
        .RojoA(ra), .AmarilloA(aa), .VerdeA(va),
        .RojoB(rb), .AmarilloB(ab), .VerdeB(vb),
        .Tick1s(tick)
    );

    semaforo_temporizador #(
        .CLK_HZ(10), .T_VERDE(9), .T_AMARILLO(1), .T_TODOROJO(1)
    ) u_dut1 (
        .Clk(clk), .Reset_n(rst_n),
`ifdef SEMAFORO_PEATON_EN
        .Peaton(peaton),
`endif
        .Numero(numero1),
        .RojoA(ra1), .AmarilloA(aa1), .VerdeA(va1),
        .RojoB(rb1), .AmarilloB(ab1), .VerdeB(vb1),
        .Tick1s(tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [9:0] q[$];
    bit sb_on = 1'b0;

    // lamp order {RA,AA,VA,RB,AB,VB}
    logic [5:0] tab_lamps [6] = '{
        6'b001_100, 6'b010_100, 6'b100_100,
        6'b100_001, 6'b100_010, 6'b100_100
    };
    int tab_dur [6] = '{9, 3, 1, 9, 3, 1};

    logic [5:0] lamps;
    assign lamps = {ra, aa, va, rb, ab, vb};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_phases(input int nphases);
        for (int p = 0; p < nphases; p++)
            for (int n = tab_dur[p % 6]; n >= 1; n--)
                q.push_back({tab_lamps[p % 6], 4'(n)});
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget && q.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        sb_on = 1'b0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_numero"}, numero, 9);
        chk({name, "_lamps"}, lamps, 6'b001_100);
        chk({name, "_tick"}, tick, 0);
    endtask

    // monitor: tick spacing, lamp invariants, scoreboard pop on each tick
    int since = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            since = 0;
        end else begin
            since++;
            chk("one_lamp_a", $countones(lamps[5:3]), 1);
            chk("one_lamp_b", $countones(lamps[2:0]), 1);
            chk("no_double_green", int'(va & vb), 0);
            if (tick) begin
                chk("tick_spacing", since, 10);
                since = 0;
                if (sb_on && q.size() > 0) begin
                    logic [9:0] e;
                    e = q.pop_front();
                    chk("sb_lamps", lamps, e[9:4]);
                    chk("sb_numero", numero, e[3:0]);
                end
            end
        end
    end

    // short-yellow instance: each yellow run lasts 10 cycles showing 1
    int run1 = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run1 = 0;
        end else if (aa1 || ab1) begin
            run1++;
            chk("y1_numero", numero1, 1);
        end else if (run1 != 0) begin
            chk("y1_length", run1, 10);
            run1 = 0;
        end
    end

    initial begin
        int i;
        rst_n = 1'b1;
`ifdef SEMAFORO_PEATON_EN
        peaton = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset_async");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_reset_vals("reset_hold");
        end

        // two full cycles from release
        push_phases(12);
        sb_on = 1'b1;
        #1 rst_n = 1'b1;
        drain(700);

        // mid-phase reset at B_VERDE, Numero=5, prescaler=4
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (vb && numero == 4'd5) break;
        end
        chk("reach_bverde_5", i < 400, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midphase_async");
        repeat (2) @(negedge clk);
        chk_reset_vals("midphase_hold");
        q.delete();
        push_phases(3);
        sb_on = 1'b1;
        #1 rst_n = 1'b1;
        drain(250);

`ifdef SEMAFORO_PEATON_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (va && numero == 4'd7) break;
        end
        chk("reach_averde_7", i < 200, 1);
        #1 peaton = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("peaton_force3", numero, 3);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (numero == 4'd2) break;
        end
        chk("reach_averde_2", i < 100, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("peaton_at2_numero", numero, 1);
        chk("peaton_at2_green", va, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("peaton_amarillo_lamps", lamps, 6'b010_100);
        chk("peaton_amarillo_num", numero, 3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("peaton_amarillo_dec", numero, 2);
        peaton = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
